board_update_seq: RTL and testbench

//  Sequences one player move on the 8x8 board (3-bit cells, 0 = empty).
//  - Accepts a clear mask from the match finder and zeroes the selected cells.
//  - Iterates the combinational refresh (gravity + empty-column left shift) until the board is stable.
//  - Holds each intermediate board for a programmable time so the VGA path can animate it.
//  - Owns the board register; sits between input/match logic and the display/score blocks.

---
 rtl/board_pkg.sv | 25 ++
 rtl/board_mask_apply.sv | 27 ++
 rtl/board_update_seq.sv | 113 +++++++++++
 tb/tb_board_update_seq.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared geometry, cell addressing and sequencer state encoding for the 8x8 match board.
package board_pkg;

  localparam int ROWS    = 8;
  localparam int COLS    = 8;
  localparam int CELLS   = ROWS * COLS;
  localparam int CELL_W  = 3;
  localparam int BOARD_W = CELLS * CELL_W;
  localparam int CNT_W   = 7;
  localparam logic [CELL_W-1:0] EMPTY = 3'd0;

  // Bit offset of cell (r,c) inside a packed board vector.
  function automatic int idx(input int r, input int c);
    return (COLS * r + c) * CELL_W;
  endfunction

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    SETTLE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } seq_state_t;

endpackage

// File: rtl/board_mask_apply.sv
// Zeroes the masked cells of a board and counts how many of them were occupied.
module board_mask_apply
  import board_pkg::*;
(
  input  logic [BOARD_W-1:0] board_in,
  input  logic [CELLS-1:0]   mask,
  output logic [BOARD_W-1:0] board_out,
  output logic [CNT_W-1:0]   cleared
);

  logic [CELLS-1:0] hit;

  for (genvar gi = 0; gi < CELLS; gi++) begin : g_cell
    localparam int BASE = idx(gi / COLS, gi % COLS);
    assign hit[gi] = mask[gi] && (board_in[BASE +: CELL_W] != EMPTY);
    assign board_out[BASE +: CELL_W] = mask[gi] ? EMPTY : board_in[BASE +: CELL_W];
  end

  // Masked cells that were already empty do not contribute to the count.
  always_comb begin
    cleared = '0;
    for (int i = 0; i < CELLS; i++) begin
      cleared = cleared + CNT_W'(hit[i]);
    end
  end

endmodule

// File: rtl/board_update_seq.sv
// Owns the board register and sequences clear -> repeated refresh -> hold for one player move.
module board_update_seq
  import board_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int MAX_ITER    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               init_valid,
  input  logic [BOARD_W-1:0] init_board,
  input  logic               move_valid,
  output logic               move_ready,
  input  logic [CELLS-1:0]   clear_mask,
  output logic [BOARD_W-1:0] refresh_in,
  input  logic [BOARD_W-1:0] refresh_out,
  output logic [BOARD_W-1:0] board,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   cleared_cnt,
  output logic               settle_err
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

  seq_state_t         state_reg;
  logic [BOARD_W-1:0] board_reg;
  logic [CELLS-1:0]   mask_reg;
  logic [3:0]         iter_reg;
  logic [HW-1:0]      hold_cnt_reg;
  logic [CNT_W-1:0]   cleared_cnt_reg;
  logic               settle_err_reg;

  logic [BOARD_W-1:0] masked_board;
  logic [CNT_W-1:0]   masked_count;
  logic               accept;

  board_mask_apply u_mask_apply (
    .board_in  (board_reg),
    .mask      (mask_reg),
    .board_out (masked_board),
    .cleared   (masked_count)
  );

  assign move_ready  = (state_reg == IDLE) && !init_valid;
  assign accept      = move_valid && move_ready;
  assign refresh_in  = board_reg;
  assign board       = board_reg;
  assign busy        = (state_reg != IDLE);
  assign done        = (state_reg == DONE);
  assign cleared_cnt = cleared_cnt_reg;
  assign settle_err  = settle_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      board_reg       <= '0;
      mask_reg        <= '0;
      iter_reg        <= '0;
      hold_cnt_reg    <= '0;
      cleared_cnt_reg <= '0;
      settle_err_reg  <= 1'b0;
    end else if (init_valid) begin
      // A board load aborts any sequence silently; result status is left intact.
      board_reg    <= init_board;
      state_reg    <= IDLE;
      iter_reg     <= '0;
      hold_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            mask_reg       <= clear_mask;
            settle_err_reg <= 1'b0;
            iter_reg       <= '0;
            state_reg      <= CLEAR;
          end
        end
        CLEAR: begin
          board_reg       <= masked_board;
          cleared_cnt_reg <= masked_count;
          state_reg       <= (masked_count == '0) ? DONE : SETTLE;
        end
        SETTLE: begin
          if (refresh_out == board_reg) begin
            state_reg <= DONE;
          end else if (iter_reg == 4'(MAX_ITER)) begin
            settle_err_reg <= 1'b1;
            state_reg      <= DONE;
          end else begin
            board_reg    <= refresh_out;
            iter_reg     <= (iter_reg == 4'hF) ? iter_reg : iter_reg + 4'd1;
            hold_cnt_reg <= HW'(HOLD_CYCLES);
            state_reg    <= (HOLD_CYCLES != 0) ? HOLD : SETTLE;
          end
        end
        HOLD: begin
          hold_cnt_reg <= hold_cnt_reg - HW'(1);
          if (hold_cnt_reg == HW'(1)) begin
            state_reg <= SETTLE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_board_update_seq.sv
// Drives directed and random moves into board_update_seq and checks them against a move-level model.
module tb_board_update_seq;
  import board_pkg::*;

  localparam int HOLD = 4;
  localparam int MAXI = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               init_valid = 1'b0;
  logic [BOARD_W-1:0] init_board = '0;
  logic               move_valid = 1'b0;
  logic               move_ready;
  logic [CELLS-1:0]   clear_mask = '0;
  logic [BOARD_W-1:0] refresh_in;
  logic [BOARD_W-1:0] refresh_out;
  logic [BOARD_W-1:0] board;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   cleared_cnt;
  logic               settle_err;

  logic               toggle_mode = 1'b0;
  logic [BOARD_W-1:0] model_board = '0;
  int                 n_checks = 0;
  int                 n_fail = 0;

  board_update_seq #(.HOLD_CYCLES(HOLD), .MAX_ITER(MAXI)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .init_valid  (init_valid),
    .init_board  (init_board),
    .move_valid  (move_valid),
    .move_ready  (move_ready),
    .clear_mask  (clear_mask),
    .refresh_in  (refresh_in),
    .refresh_out (refresh_out),
    .board       (board),
    .busy        (busy),
    .done        (done),
    .cleared_cnt (cleared_cnt),
    .settle_err  (settle_err)
  );

  always #5 clk = ~clk;

  // Full gravity (cells fall to row 7) followed by packing non-empty columns to the left.
  function automatic logic [BOARD_W-1:0] ref_refresh(input logic [BOARD_W-1:0] b);
    logic [BOARD_W-1:0] o;
    logic [2:0]         stk [8];
    logic [2:0]         v;
    int                 n;
    int                 oc;
    o  = '0;
    oc = 0;
    for (int c = 0; c < 8; c++) begin
      n = 0;
      for (int k = 0; k < 8; k++) stk[k] = 3'd0;
      for (int r = 7; r >= 0; r--) begin
        v = b[(8 * r + c) * 3 +: 3];
        if (v != 3'd0) begin
          stk[n] = v;
          n++;
        end
      end
      if (n > 0) begin
        for (int k = 0; k < n; k++) o[(8 * (7 - k) + oc) * 3 +: 3] = stk[k];
        oc++;
      end
    end
    return o;
  endfunction

  function automatic logic [BOARD_W-1:0] model_ref(input logic [BOARD_W-1:0] b);
    return toggle_mode ? (b ^ BOARD_W'(1)) : ref_refresh(b);
  endfunction

  always_comb refresh_out = model_ref(refresh_in);

  task automatic check(input string tag, input logic [BOARD_W-1:0] got, input logic [BOARD_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_init(input logic [BOARD_W-1:0] b);
    @(negedge clk);
    init_valid = 1'b1;
    init_board = b;
    @(posedge clk);
    #1;
    init_valid  = 1'b0;
    model_board = b;
  endtask

  // Call at a negedge in IDLE; returns #1 after the accept edge.
  task automatic start_move(input logic [CELLS-1:0] m);
    move_valid = 1'b1;
    clear_mask = m;
    @(posedge clk);
    #1;
    move_valid = 1'b0;
  endtask

  task automatic do_move(input string name, input logic [CELLS-1:0] m, input int lat_req);
    logic [BOARD_W-1:0] mb, eb, nb, prev;
    int  cnt, p, lat_exp, lat, upd, upd_exp;
    logic err;
    mb  = model_board;
    cnt = 0;
    for (int i = 0; i < CELLS; i++) begin
      if (m[i] && mb[i * 3 +: 3] != 3'd0) begin
        cnt++;
        mb[i * 3 +: 3] = 3'd0;
      end
    end
    p   = 0;
    err = 1'b0;
    eb  = mb;
    if (cnt == 0) begin
      lat_exp = 2;
    end else begin
      for (int it = 0; it <= MAXI; it++) begin
        nb = model_ref(eb);
        if (nb == eb) break;
        if (p == MAXI) begin
          err = 1'b1;
          break;
        end
        eb = nb;
        p++;
      end
      lat_exp = 3 + p * (1 + HOLD);
    end
    upd_exp = ((cnt > 0) ? 1 : 0) + p;

    @(negedge clk);
    check({name, "/ready"}, BOARD_W'(move_ready), BOARD_W'(1));
    check({name, "/start_board"}, board, model_board);
    start_move(m);
    lat  = -1;
    upd  = 0;
    prev = model_board;
    for (int k = 1; k <= lat_exp + 10; k++) begin
      @(negedge clk);
      if (board !== prev) begin
        upd++;
        prev = board;
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    check({name, "/latency"}, BOARD_W'(lat), BOARD_W'(lat_exp));
    if (lat_req >= 0) check({name, "/latency_abs"}, BOARD_W'(lat), BOARD_W'(lat_req));
    check({name, "/board"}, board, eb);
    check({name, "/cleared_cnt"}, BOARD_W'(cleared_cnt), BOARD_W'(cnt));
    check({name, "/settle_err"}, BOARD_W'(settle_err), BOARD_W'(err));
    check({name, "/updates"}, BOARD_W'(upd), BOARD_W'(upd_exp));
    @(negedge clk);
    check({name, "/done_width"}, BOARD_W'(done), BOARD_W'(0));
    check({name, "/idle_ready"}, BOARD_W'(move_ready), BOARD_W'(1));
    model_board = eb;
    $display("move %s mask=%016h cleared=%0d passes=%0d err=%0d latency=%0d", name, m, cnt, p, err, lat);
  endtask

  function automatic logic [BOARD_W-1:0] rand_board();
    logic [BOARD_W-1:0] b;
    int v;
    b = '0;
    for (int i = 0; i < CELLS; i++) begin
      v = $urandom_range(0, 11);
      b[i * 3 +: 3] = (v > 7) ? 3'd0 : 3'(v);
    end
    return b;
  endfunction

  function automatic logic [CELLS-1:0] occupied(input logic [BOARD_W-1:0] b);
    logic [CELLS-1:0] o;
    for (int i = 0; i < CELLS; i++) o[i] = (b[i * 3 +: 3] != 3'd0);
    return o;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BOARD_W-1:0] b, exp_b, y;
    logic [CELLS-1:0]   m;
    logic [CNT_W-1:0]   saved_cnt;

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset/board", board, '0);
    check("reset/busy", BOARD_W'(busy), BOARD_W'(0));
    check("reset/ready", BOARD_W'(move_ready), BOARD_W'(1));
    check("reset/done", BOARD_W'(done), BOARD_W'(0));
    check("reset/cleared_cnt", BOARD_W'(cleared_cnt), BOARD_W'(0));
    check("reset/settle_err", BOARD_W'(settle_err), BOARD_W'(0));

    // Single drop
    b = '0;
    b[idx(0, 0) +: 3] = 3'd3;
    b[idx(7, 0) +: 3] = 3'd5;
    do_init(b);
    m = '0;
    m[56] = 1'b1;
    do_move("single_drop", m, 4 + HOLD);
    exp_b = '0;
    exp_b[idx(7, 0) +: 3] = 3'd3;
    check("single_drop/hand_board", board, exp_b);

    // Column collapse
    b = '0;
    exp_b = '0;
    m = '0;
    for (int r = 0; r < 8; r++) begin
      b[idx(r, 0) +: 3] = 3'd2;
      b[idx(r, 1) +: 3] = 3'd4;
      exp_b[idx(r, 0) +: 3] = 3'd4;
      m[8 * r] = 1'b1;
    end
    do_init(b);
    do_move("column_collapse", m, -1);
    check("column_collapse/hand_board", board, exp_b);
    check("column_collapse/hand_cnt", BOARD_W'(cleared_cnt), BOARD_W'(8));

    // Null moves
    do_move("null_zero_mask", '0, 2);
    do_move("null_empty_cells", ~occupied(model_board), 2);

    // Simultaneous init and move in IDLE
    y = rand_board();
    @(negedge clk);
    init_valid = 1'b1;
    init_board = y;
    move_valid = 1'b1;
    clear_mask = '1;
    #1;
    check("init_vs_move/ready", BOARD_W'(move_ready), BOARD_W'(0));
    @(posedge clk);
    #1;
    init_valid = 1'b0;
    move_valid = 1'b0;
    model_board = y;
    @(negedge clk);
    check("init_vs_move/busy", BOARD_W'(busy), BOARD_W'(0));
    check("init_vs_move/board", board, y);

    // Init during HOLD aborts without a done pulse
    b = '0;
    b[idx(0, 3) +: 3] = 3'd6;
    b[idx(7, 3) +: 3] = 3'd1;
    do_init(b);
    m = '0;
    m[59] = 1'b1;
    exp_b = '0;
    exp_b[idx(7, 0) +: 3] = 3'd6;
    @(negedge clk);
    start_move(m);
    repeat (4) @(negedge clk);
    check("init_in_hold/busy", BOARD_W'(busy), BOARD_W'(1));
    check("init_in_hold/mid_board", board, exp_b);
    y = rand_board();
    init_valid = 1'b1;
    init_board = y;
    @(posedge clk);
    #1;
    init_valid = 1'b0;
    model_board = y;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("init_in_hold/no_done", BOARD_W'(done), BOARD_W'(0));
      check("init_in_hold/idle", BOARD_W'(busy), BOARD_W'(0));
    end
    check("init_in_hold/board", board, y);

    // Never-stabilising refresh hits the pass limit
    b = '0;
    b[idx(7, 0) +: 3] = 3'd2;
    b[idx(7, 1) +: 3] = 3'd3;
    do_init(b);
    toggle_mode = 1'b1;
    m = '0;
    m[57] = 1'b1;
    do_move("settle_limit", m, 3 + MAXI * (1 + HOLD));
    check("settle_limit/err_hand", BOARD_W'(settle_err), BOARD_W'(1));
    saved_cnt = 7'd1;
    toggle_mode = 1'b0;
    do_init(rand_board());
    @(negedge clk);
    check("init_keeps/settle_err", BOARD_W'(settle_err), BOARD_W'(1));
    check("init_keeps/cleared_cnt", BOARD_W'(cleared_cnt), BOARD_W'(saved_cnt));

    // Reset asserted mid-sequence
    toggle_mode = 1'b1;
    b = '0;
    b[idx(7, 0) +: 3] = 3'd5;
    b[idx(7, 2) +: 3] = 3'd7;
    do_init(b);
    m = '0;
    m[58] = 1'b1;
    @(negedge clk);
    start_move(m);
    repeat (4) @(negedge clk);
    check("reset_in_hold/busy_before", BOARD_W'(busy), BOARD_W'(1));
    rst_n = 1'b0;
    #1;
    check("reset_in_hold/board", board, '0);
    check("reset_in_hold/busy", BOARD_W'(busy), BOARD_W'(0));
    check("reset_in_hold/done", BOARD_W'(done), BOARD_W'(0));
    check("reset_in_hold/cleared_cnt", BOARD_W'(cleared_cnt), BOARD_W'(0));
    check("reset_in_hold/settle_err", BOARD_W'(settle_err), BOARD_W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    toggle_mode = 1'b0;
    model_board = '0;

    // Random moves
    for (int t = 0; t < 25; t++) begin
      do_init(rand_board());
      case ($urandom_range(0, 3))
        0:       m = '0;
        1:       m = {$urandom, $urandom} & {$urandom, $urandom};
        2:       m = {$urandom, $urandom};
        default: m = ~occupied(model_board);
      endcase
      do_move($sformatf("rand%0d", t), m, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
